// File: rtl/wb_posted_write_buffer.sv
// Posted-write buffer between a Wishbone master and an arbitrator master port.
// Writes are acked at once and queued; reads wait for the queue to drain, then pass through.
module wb_posted_write_buffer #(
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_we_i,
  input  logic               s_cyc_i,
  input  logic               s_stb_i,
  input  logic [3:0]         s_sel_i,
  input  logic [31:0]        s_adr_i,
  input  logic [31:0]        s_dat_i,
  output logic [31:0]        s_dat_o,
  output logic               s_ack_o,
  output logic               s_int_o,
  output logic               m_we_o,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic [3:0]         m_sel_o,
  output logic [31:0]        m_adr_o,
  output logic [31:0]        m_dat_o,
  input  logic [31:0]        m_dat_i,
  input  logic               m_ack_i,
  input  logic               m_int_i,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned Depth  = 2 ** FIFO_AW;
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [FIFO_AW:0] FullCnt = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0] OneCnt  = (FIFO_AW + 1)'(1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

  typedef enum logic [2:0] {StIdle, StWr, StGap, StRd, StRdAck} state_e;

  state_e              state_q, state_d;
  logic [67:0]         mem_q [Depth];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [31:0]         rd_adr_q, s_dat_q;
  logic [3:0]          rd_sel_q;
  logic                rd_live_q, s_ack_q, s_int_q;

  logic        full, empty, in_rd, push, pop, rd_pending, rd_start, rd_deliver;
  logic [67:0] head;

  assign full       = (count_q == FullCnt);
  assign empty      = (count_q == '0);
  assign in_rd      = (state_q == StRd) || (state_q == StRdAck);
  assign push       = s_cyc_i & s_stb_i & s_we_i & ~s_ack_q & ~full & ~in_rd;
  assign rd_pending = s_cyc_i & s_stb_i & ~s_we_i & ~s_ack_q;
  // Read data goes upstream only if the master kept its cycle for the whole read.
  assign rd_deliver = (state_q == StRd) & m_ack_i & rd_live_q & s_cyc_i;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    pop      = 1'b0;
    rd_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StWr;
        end else if (rd_pending) begin
          state_d  = StRd;
          rd_start = 1'b1;
        end
      end
      StWr: begin
        if (m_ack_i) begin
          pop     = 1'b1;
          burst_d = burst_q + BurstW'(1);
          if (burst_d == BurstMax) begin
            state_d = StGap;
          end else if (count_q == OneCnt && !push) begin
            state_d = StIdle;
            burst_d = '0;
          end
        end
      end
      StGap: begin
        // Single release cycle; resume draining directly so cyc drops for exactly one cycle.
        burst_d = '0;
        state_d = empty ? StIdle : StWr;
      end
      StRd: begin
        if (m_ack_i) state_d = StRdAck;
      end
      StRdAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + OneCnt;
    else if (pop && !push) count_d = count_q - OneCnt;
  end

  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = '0;
    m_adr_o = '0;
    m_dat_o = '0;
    if (state_q == StWr) begin
      m_cyc_o = 1'b1;
      m_stb_o = 1'b1;
      m_we_o  = 1'b1;
      m_sel_o = head[67:64];
      m_adr_o = head[63:32];
      m_dat_o = head[31:0];
    end else if (state_q == StRd) begin
      m_cyc_o = 1'b1;
      m_stb_o = 1'b1;
      m_sel_o = rd_sel_q;
      m_adr_o = rd_adr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_sel_i, s_adr_i, s_dat_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      burst_q   <= '0;
      rd_adr_q  <= '0;
      rd_sel_q  <= '0;
      rd_live_q <= 1'b0;
      s_dat_q   <= '0;
      s_ack_q   <= 1'b0;
      s_int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      burst_q <= burst_d;
      s_ack_q <= push | rd_deliver;
      s_int_q <= m_int_i;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rd_start) begin
        rd_adr_q  <= s_adr_i;
        rd_sel_q  <= s_sel_i;
        rd_live_q <= 1'b1;
      end else if (state_q == StRd && !s_cyc_i) begin
        rd_live_q <= 1'b0;
      end
      if (rd_deliver) s_dat_q <= m_dat_i;
    end
  end

  assign s_dat_o    = s_dat_q;
  assign s_ack_o    = s_ack_q;
  assign s_int_o    = s_int_q;
  assign fifo_count = count_q;

endmodule
